// File: rtl/decade_pkg.sv
// rtl/decade_pkg.sv - shared state encodings and BCD constants for the decade counter chain
package decade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         BCD_W     = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one mod-10 decade of the chain; falling-edge flops, async active-low reset
module bcd_digit
  import decade_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_in,
  input  logic             load_zero,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_zero) begin
      q_d = '0;
    end else if (inc_in) begin
      q_d = (q_q == DIGIT_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc_in && (q_q == DIGIT_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// rtl/decade_chain_ctrl.sv - run/pause/clear sequencer, prescaler and terminal compare for a BCD chain
// Optional lap capture register and ports are built when DECADE_LAP_CAPTURE_EN is defined.
module decade_chain_ctrl
  import decade_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  auto_reload,
  input  logic [4*DIGITS-1:0]   limit,
`ifdef DECADE_LAP_CAPTURE_EN
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_count,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic [1:0]            state
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                done_q, done_d;
  logic                chain_inc;
  logic                chain_zero;
  logic                at_limit;
  logic                tick;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] count_w;
  logic                unused_chain_wrap;

  // Digits never exceed 9, so a limit holding a non-BCD nibble simply never matches.
  assign at_limit = (count_w == limit);
  assign tick     = (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    chain_inc  = 1'b0;
    chain_zero = 1'b0;
    if (clear) begin
      state_d    = ST_IDLE;
      presc_d    = '0;
      chain_zero = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (at_limit) begin
              done_d = 1'b1;
              if (auto_reload) begin
                chain_zero = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              chain_inc = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && !stop) begin
            state_d    = ST_RUN;
            presc_d    = '0;
            chain_zero = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  // Ripple carry: digit k steps only when the tick passed through every lower 9.
  assign carry[0] = chain_inc;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .inc_in    (carry[k]),
      .load_zero (chain_zero),
      .q         (count_w[4*k +: 4]),
      .carry_out (carry[k+1])
    );
  end

  assign unused_chain_wrap = carry[DIGITS];

`ifdef DECADE_LAP_CAPTURE_EN
  logic [4*DIGITS-1:0] lap_q, lap_d;

  // Captures the pre-tick count when a lap lands on the same edge as a tick.
  always_comb begin
    lap_d = lap_q;
    if (clear) begin
      lap_d = '0;
    end else if (lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_d = count_w;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_count = lap_q;
`endif

  assign count   = count_w;
  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// tb/tb_decade_chain_ctrl.sv - self-checking bench for decade_chain_ctrl (DIGITS=2, PRESCALE=3)
module tb_decade_chain_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 3;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count;
  logic         running;
  logic         done;
  logic [1:0]   state;
`ifdef DECADE_LAP_CAPTURE_EN
  logic         lap = 1'b0;
  logic [W-1:0] lap_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: decimal count value, prescaler phase, state code 0..3
  int m_state;
  int m_cnt;
  int m_presc;
  int m_lap;
  bit m_done;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .auto_reload (auto_reload),
    .limit       (limit),
`ifdef DECADE_LAP_CAPTURE_EN
    .lap         (lap),
    .lap_count   (lap_count),
`endif
    .count       (count),
    .running     (running),
    .done        (done),
    .state       (state)
  );

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int lim_value(logic [W-1:0] l);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (l[4*k +: 4] > 4'd9) return -1;
      v = v + p * int'(l[4*k +: 4]);
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_presc = 0;
    m_lap   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge();
    int lv;
    lv     = lim_value(limit);
    m_done = 1'b0;
    if (clear) begin
      m_state = 0;
      m_cnt   = 0;
      m_presc = 0;
      m_lap   = 0;
    end else begin
`ifdef DECADE_LAP_CAPTURE_EN
      if (lap && (m_state == 1 || m_state == 2)) m_lap = m_cnt;
`endif
      case (m_state)
        0: if (start && !stop) begin m_state = 1; m_presc = 0; end
        1: begin
          if (stop) begin
            m_state = 2;
          end else if (m_presc == PRESCALE - 1) begin
            m_presc = 0;
            if (lv >= 0 && m_cnt == lv) begin
              m_done = 1'b1;
              if (auto_reload) m_cnt = 0;
              else m_state = 3;
            end else begin
              m_cnt = (m_cnt + 1) % MOD;
            end
          end else begin
            m_presc = m_presc + 1;
          end
        end
        2: if (start && !stop) m_state = 1;
        default: if (start && !stop) begin m_state = 1; m_cnt = 0; m_presc = 0; end
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (count !== '0) begin n_err++; $display("FAIL reset_count got=%h exp=00", count); end
    n_vec++;
    if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_vec++;
    if ({running, done} !== 2'b00) begin n_err++; $display("FAIL reset_flags got run=%b done=%b exp 0/0", running, done); end
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_run();
    int done_at;
    int n_done;
    clear = 1'b1; step(); clear = 1'b0;
    limit = 8'h12; auto_reload = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    done_at = -1;
    n_done  = 0;
    for (int i = 1; i <= 45; i++) begin
      step();
      n_vec++;
      if ({count, state, running, done} !== {to_bcd(m_cnt), 2'(m_state), m_state == 1, m_done}) begin
        n_err++;
        $display("FAIL basic_run cyc=%0d got count=%h state=%0d run=%b done=%b exp count=%h state=%0d done=%b",
                 i, count, state, running, done, to_bcd(m_cnt), m_state, m_done);
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
    end
    n_vec++;
    if (done_at != 39) begin n_err++; $display("FAIL basic_done_cycle got=%0d exp=39", done_at); end
    n_vec++;
    if (n_done != 1) begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    n_vec++;
    if ({state, count} !== {2'd3, 8'h12}) begin n_err++; $display("FAIL basic_hold got state=%0d count=%h exp 3/12", state, count); end
  endtask

  task automatic test_carry_wrap();
    int n_done;
    limit = 8'hFF; auto_reload = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9 * PRESCALE; i++) step();
    n_vec++;
    if (count !== 8'h09) begin n_err++; $display("FAIL carry_at09 got=%h exp=09", count); end
    repeat (PRESCALE) step();
    n_vec++;
    if (count !== 8'h10) begin n_err++; $display("FAIL carry_09_10 got=%h exp=10", count); end
    n_done = 0;
    for (int i = 0; i < 89 * PRESCALE; i++) begin step(); if (done) n_done++; end
    n_vec++;
    if (count !== 8'h99) begin n_err++; $display("FAIL carry_at99 got=%h exp=99", count); end
    for (int i = 0; i < PRESCALE; i++) begin step(); if (done) n_done++; end
    n_vec++;
    if ({count, state} !== {8'h00, 2'd1}) begin n_err++; $display("FAIL wrap_99_00 got count=%h state=%0d exp 00/1", count, state); end
    n_vec++;
    if (n_done != 0) begin n_err++; $display("FAIL wrap_no_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_pause_resume();
    limit = 8'hFF;
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5 * PRESCALE + 1; i++) step();
    n_vec++;
    if (count !== 8'h05 || m_presc != 1) begin n_err++; $display("FAIL pause_setup got=%h exp=05", count); end
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({count, state, running} !== {8'h05, 2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL pause_hold cyc=%0d got count=%h state=%0d run=%b exp 05/2/0", i, count, state, running);
      end
    end
    start = 1'b1; step(); start = 1'b0;
    n_vec++;
    if ({count, state} !== {8'h05, 2'd1}) begin n_err++; $display("FAIL resume_edge got count=%h state=%0d exp 05/1", count, state); end
    step();
    n_vec++;
    if (count !== 8'h05) begin n_err++; $display("FAIL resume_plus1 got=%h exp=05", count); end
    step();
    n_vec++;
    if (count !== 8'h06) begin n_err++; $display("FAIL resume_plus2 got=%h exp=06", count); end
  endtask

  task automatic test_auto_reload();
    int n_done;
    limit = 8'h03; auto_reload = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      n_vec++;
      if ({count, state, done} !== {to_bcd(m_cnt), 2'(m_state), m_done} || state !== 2'd1) begin
        n_err++;
        $display("FAIL auto_reload cyc=%0d got count=%h state=%0d done=%b exp count=%h state=1 done=%b",
                 i, count, state, done, to_bcd(m_cnt), m_done);
      end
      if (done) begin
        n_done++;
        n_vec++;
        if (i % 12 != 0) begin n_err++; $display("FAIL auto_period got cyc=%0d exp multiple of 12", i); end
      end
    end
    n_vec++;
    if (n_done != 5) begin n_err++; $display("FAIL auto_done_count got=%0d exp=5", n_done); end
    auto_reload = 1'b0;
  endtask

  task automatic test_priority();
    limit = 8'hFF;
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 37 * PRESCALE; i++) step();
    n_vec++;
    if ({count, state} !== {8'h37, 2'd1}) begin n_err++; $display("FAIL prio_setup got count=%h state=%0d exp 37/1", count, state); end
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    n_vec++;
    if ({count, state, running} !== {8'h00, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL prio_clear got count=%h state=%0d run=%b exp 00/0/0", count, state, running);
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_vec++;
    if (state !== 2'd0) begin n_err++; $display("FAIL prio_stop_idle got state=%0d exp=0", state); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    n_vec++;
    if (count !== 8'h02) begin n_err++; $display("FAIL areset_setup got=%h exp=02", count); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({count, state, running, done} !== {8'h00, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL areset_immediate got count=%h state=%0d run=%b done=%b exp 00/0/0/0", count, state, running, done);
    end
    model_reset();
    #1;
    rst = 1'b1;
    step();
    n_vec++;
    if ({count, state} !== {8'h00, 2'd0}) begin n_err++; $display("FAIL areset_after got count=%h state=%0d exp 00/0", count, state); end
  endtask

`ifdef DECADE_LAP_CAPTURE_EN
  task automatic test_lap();
    int guard;
    limit = 8'hFF; auto_reload = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!(m_cnt == 21 && m_presc == PRESCALE - 1) && guard < 500) begin step(); guard++; end
    n_vec++;
    if (guard >= 500) begin n_err++; $display("FAIL lap_timeout got guard=%0d exp <500", guard); end
    lap = 1'b1; step(); lap = 1'b0;
    n_vec++;
    if ({lap_count, count} !== {8'h21, 8'h22}) begin
      n_err++;
      $display("FAIL lap_tick got lap_count=%h count=%h exp 21/22", lap_count, count);
    end
    clear = 1'b1; step(); clear = 1'b0;
    n_vec++;
    if (lap_count !== 8'h00) begin n_err++; $display("FAIL lap_clear got=%h exp=00", lap_count); end
    lap = 1'b1; step(); lap = 1'b0;
    n_vec++;
    if (lap_count !== 8'h00) begin n_err++; $display("FAIL lap_idle got=%h exp=00", lap_count); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        if ($urandom_range(0, 3) == 0) limit = W'($urandom);
        else limit = to_bcd(int'($urandom_range(0, 15)));
        auto_reload = 1'($urandom_range(0, 1));
      end
      clear = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 15);
`ifdef DECADE_LAP_CAPTURE_EN
      lap   = ($urandom_range(0, 99) < 10);
`endif
      step();
      n_vec++;
      if ({count, state, running, done} !== {to_bcd(m_cnt), 2'(m_state), m_state == 1, m_done}) begin
        n_err++;
        $display("FAIL random cyc=%0d lim=%h got count=%h state=%0d run=%b done=%b exp count=%h state=%0d done=%b",
                 i, limit, count, state, running, done, to_bcd(m_cnt), m_state, m_done);
      end
`ifdef DECADE_LAP_CAPTURE_EN
      n_vec++;
      if (lap_count !== to_bcd(m_lap)) begin
        n_err++;
        $display("FAIL random_lap cyc=%0d got=%h exp=%h", i, lap_count, to_bcd(m_lap));
      end
`endif
    end
    clear = 1'b0; stop = 1'b0; start = 1'b0;
`ifdef DECADE_LAP_CAPTURE_EN
    lap = 1'b0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_run();
    test_carry_wrap();
    test_pause_resume();
    test_auto_reload();
    test_priority();
    test_async_reset();
`ifdef DECADE_LAP_CAPTURE_EN
    test_lap();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decade_chain_ctrl.md
Name: decade_chain_ctrl

Overview:
Run controller for a chain of cascaded mod-10 (BCD) digit counters. It sequences start, stop, resume and clear, generates the count tick from a prescaler, and ripples carries across the digits. It also compares the chain against a programmable terminal value. The block sits between the user control inputs and the 7-segment/display logic and is the single owner of the digit chain.

Parameters:
DIGITS, 2, number of BCD digits in the chain (1..8)
PRESCALE, 10, clk cycles per count tick (>=1)

Ports:
clk  input  1  system clock; all flops update on the falling edge
rst  input  1  asynchronous, active-low reset
start  input  1  level-sampled; run from IDLE/DONE (restart) or resume from PAUSE
stop  input  1  level-sampled; pause while running
clear  input  1  level-sampled; synchronous return to IDLE with count 0
auto_reload  input  1  1 = wrap to 0 at terminal value and keep running
limit  input  4*DIGITS  BCD terminal value; digit k is bits [4k+3:4k]
count  output  4*DIGITS  current BCD count
running  output  1  high while in RUN
done  output  1  one-cycle pulse on terminal tick
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0; prescaler=0; done=0; running=0.
  - Reset mid-run discards everything; no done pulse is produced.
- Control priority each edge: clear > stop > start.
- clear: takes effect in any state. Sets state=IDLE, count=0, prescaler=0, done=0.
- IDLE:
  - start -> RUN, prescaler=0, count held.
  - stop is ignored.
- RUN:
  - running=1.
  - Prescaler counts 0..PRESCALE-1. A tick occurs on the edge where the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - On a tick with count != limit: digit 0 increments. Digit k increments only when every lower digit equals 9. Each digit wraps 9 -> 0. All-9s wraps to all-0s.
  - On a tick with count == limit: done=1 for exactly one cycle.
    - If auto_reload=1: count=0 and the block stays in RUN. This makes it a mod-(limit+1) counter.
    - If auto_reload=0: state=DONE and count holds at limit.
  - Terminal period is (limit+1)*PRESCALE cycles from start.
  - stop -> PAUSE. The prescaler and count freeze, and no tick occurs on that edge.
- PAUSE:
  - Everything is held.
  - start -> RUN; the prescaler resumes from its held value.
- DONE:
  - Count held at limit.
  - start -> RUN with count=0 and prescaler=0.
- limit containing any digit >9: never matches. The chain wraps freely and done never fires.
- start asserted with stop on the same edge: stop wins; from IDLE, no transition.
- Latency: start sampled at edge N gives running=1 after edge N. The first increment occurs at edge N+PRESCALE.
- Width rules:
  - The prescaler is $clog2(PRESCALE) bits, minimum 1.
  - Comparisons are exact bit equality on the full 4*DIGITS vector.

Optional Feature:
DECADE_LAP_CAPTURE_EN
- Defined: adds ports lap (input, 1) and lap_count (output, 4*DIGITS).
  - A lap pulse in RUN or PAUSE copies count into lap_count on that edge.
  - lap_count holds until the next lap, clear, or reset, which zero it.
  - If lap and a tick occur on the same edge, lap_count gets the pre-tick count.
  - lap has no effect in IDLE or DONE.
- Undefined: the lap ports and the lap register are absent. All other behaviour is identical.

Decomposition:
- Shared package decade_pkg contains:
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE
  - BCD_W=4
  - DIGIT_MAX=4'd9
- Sub-module bcd_digit: one decade instantiated DIGITS times via generate.
  - Ports: clk, rst, inc_in, load_zero; q[3:0]; carry_out = inc_in && q==9.
  - Falling-edge update, asynchronous active-low reset.
- FSM, prescaler, comparator and lap register stay in decade_chain_ctrl.

Test Plan:
All scenarios use DIGITS=2, PRESCALE=3.
- Basic run: limit=0x12, auto_reload=0, start 1 cycle.
  - count steps 0x00..0x12, one step every 3 cycles.
  - done pulses once at cycle 39; state=DONE; count holds 0x12.
- Carry and wrap: observe ticks from 0x09 and from 0x99, with limit=0xFF.
  - 0x09 -> 0x10.
  - 0x99 -> 0x00, with no done pulse.
- Pause/resume: stop when count=0x05 and prescaler=1, hold 10 cycles, then start.
  - count frozen at 0x05 throughout the pause.
  - 0x06 appears 2 cycles after resume.
- Auto-reload: limit=0x03, auto_reload=1.
  - count sequence 0,1,2,3,0,...
  - done pulses every 12 cycles; state stays RUN.
- Priority and reset: start+stop+clear together while count=0x37 in RUN gives IDLE with count=0x00.
  - Separately, rst low mid-cycle in RUN forces count=0 and state=IDLE immediately, before the next clk edge.
- Lap (macro defined): lap at count=0x21 coinciding with a tick.
  - lap_count=0x21 and count=0x22.
  - clear zeroes lap_count.
